// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit datapath among N requesters.
// A grant is locked from the first beat until the requester's Last beat is accepted.
module rr_burst_arbiter #(
   parameter int N = 4,
   parameter int WIDTH = 32,
   localparam int SELW = $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N-1:0]       Req,
   input  logic [N-1:0]       Last,
   input  logic [N*WIDTH-1:0] DataIn,
   input  logic               OutReady,
   output logic [N-1:0]       Gnt,
   output logic [SELW-1:0]    Sel,
   output logic               OutValid,
   output logic [WIDTH-1:0]   OutData,
   output logic               OutLast,
   output logic [N-1:0]       Ack,
   output logic               Busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_reg, state_next;
   logic [SELW-1:0] ptr_reg, ptr_next;
   logic [SELW-1:0] sel_reg, sel_next;
   logic [N-1:0]    gnt_reg, gnt_next;
   logic [SELW-1:0] winner;
   logic [WIDTH-1:0] words [N];
   logic            transfer;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         assign words[gi] = DataIn[gi*WIDTH +: WIDTH];
         assign Ack[gi]   = gnt_reg[gi] & transfer;
      end
   endgenerate

   // Scan from the farthest offset down so the requester nearest Ptr wins.
   always_comb begin
      int idx;
      idx    = 0;
      winner = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_reg) + k;
         if (idx >= N) idx = idx - N;
         if (Req[idx]) winner = SELW'(idx);
      end
   end

   assign Busy     = (state_reg == BUSY);
   assign OutValid = Busy & Req[sel_reg];
   assign OutData  = words[sel_reg];
   assign OutLast  = Last[sel_reg] & OutValid;
   assign transfer = OutValid & OutReady;
   assign Gnt      = gnt_reg;
   assign Sel      = sel_reg;

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      sel_next   = sel_reg;
      gnt_next   = gnt_reg;
      case (state_reg)
         IDLE: begin
            if (|Req) begin
               state_next = BUSY;
               sel_next   = winner;
               gnt_next   = {{(N-1){1'b0}}, 1'b1} << winner;
            end
         end
         BUSY: begin
            // Burst end: release and hand lowest priority to the one just served.
            if (transfer && OutLast) begin
               state_next = IDLE;
               gnt_next   = '0;
               ptr_next   = (int'(sel_reg) == N - 1) ? '0 : sel_reg + SELW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         sel_reg   <= '0;
         gnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         sel_reg   <= sel_next;
         gnt_reg   <= gnt_next;
      end
   end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: directed scenarios plus random traffic,
// all checked against a burst-level reference model.
module tb_rr_burst_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int SELW = $clog2(N);

   logic             clk = 1'b0;
   logic             reset;
   logic [N-1:0]     req, last;
   logic [N*W-1:0]   data_in;
   logic             out_ready;
   logic [N-1:0]     Gnt, Ack;
   logic [SELW-1:0]  Sel;
   logic             OutValid, OutLast, Busy;
   logic [W-1:0]     OutData;

   rr_burst_arbiter #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .Req(req), .Last(last), .DataIn(data_in),
      .OutReady(out_ready), .Gnt(Gnt), .Sel(Sel), .OutValid(OutValid),
      .OutData(OutData), .OutLast(OutLast), .Ack(Ack), .Busy(Busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   // Reference model: who owns the datapath, and where the next scan starts.
   int m_busy, m_owner, m_ptr;
   int ends[$];

   function automatic int scan(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check outputs for the current inputs, then advance the model.
   task automatic step();
      logic [N-1:0] eg;
      logic ev, done;
      int w;
      #1;
      eg = '0;
      if (m_busy != 0) eg[m_owner] = 1'b1;
      ev   = (m_busy != 0) && req[m_owner];
      done = ev && out_ready && last[m_owner];
      chk("gnt", Gnt, eg);
      chk("busy", Busy, m_busy);
      chk("valid", OutValid, ev);
      chk("last", OutLast, ev && last[m_owner]);
      chk("ack", Ack, (ev && out_ready) ? eg : '0);
      chk("onehot", $onehot0(Gnt), 1);
      if (m_busy != 0) begin
         chk("sel", Sel, m_owner);
         chk("data", OutData, data_in[m_owner*W +: W]);
      end
      if (done) ends.push_back(m_owner);
      @(posedge clk);
      if (m_busy == 0) begin
         w = scan(req, m_ptr);
         if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
         end
      end else if (done) begin
         m_busy = 0;
         m_ptr  = (m_owner + 1) % N;
      end
      #1;
   endtask

   int exp_order[5] = '{0, 1, 2, 3, 0};
   int exp_wrap[2]  = '{3, 0};
   logic ready_pat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
      reset = 1'b1; req = '0; last = '0; out_ready = 1'b0;
      data_in = {$urandom, $urandom, $urandom, $urandom};
      m_busy = 0; m_owner = 0; m_ptr = 0;
      #12;
      chk("rst_gnt", Gnt, 0);
      chk("rst_sel", Sel, 0);
      chk("rst_valid", OutValid, 0);
      chk("rst_last", OutLast, 0);
      chk("rst_ack", Ack, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_data", OutData, data_in[0 +: W]);
      reset = 1'b0;
      @(posedge clk); #1;

      // Contention: all single-beat, order 0,1,2,3,0.
      req = 4'b1111; last = 4'b1111; out_ready = 1'b1; ends.delete();
      repeat (10) step();
      chk("cont_count", ends.size(), 5);
      if (ends.size() == 5)
         for (int i = 0; i < 5; i++) chk("cont_order", ends[i], exp_order[i]);

      // Move pointer to 3 by serving requester 2, then check wrap 3 -> 0.
      req = 4'b0100; last = 4'b0100;
      repeat (2) step();
      req = 4'b1001; last = 4'b1001; ends.delete();
      repeat (4) step();
      chk("wrap_count", ends.size(), 2);
      if (ends.size() == 2)
         for (int i = 0; i < 2; i++) chk("wrap_order", ends[i], exp_wrap[i]);

      // Requester 1 gaps mid-burst while requester 0 waits.
      req = 4'b0011; last = 4'b0000;
      repeat (2) step();
      req = 4'b0001;
      repeat (2) begin
         step();
         chk("gap_gnt", Gnt, 4'b0010);
      end
      req = 4'b0011; last = 4'b0010;
      step();
      step();
      chk("gap_next", Gnt, 4'b0001);

      // Back-pressure on requester 0's burst.
      last = 4'b0000; req = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         out_ready = ready_pat[i];
         step();
      end
      last = 4'b0001; out_ready = 1'b1;
      repeat (2) step();

      // Asynchronous reset during a burst.
      req = 4'b0100; last = 4'b0000;
      repeat (3) step();
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_gnt", Gnt, 0);
      chk("mid_rst_valid", OutValid, 0);
      chk("mid_rst_busy", Busy, 0);
      m_busy = 0; m_ptr = 0;
      #2 reset = 1'b0;
      req = 4'b0101; last = 4'b0101;
      step();
      chk("rst_regrant", Gnt, 4'b0001);
      repeat (2) step();

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         req       = N'($urandom & $urandom_range(15, 0) | $urandom);
         last      = N'($urandom) & N'($urandom);
         out_ready = ($urandom_range(9, 0) < 7);
         data_in   = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one downstream WIDTH-bit datapath among N requesters.
- Sequences a word-select mux (encoded Sel output) and a valid/ready handshake.
- Grants are locked for a whole burst, from the first beat until the beat flagged Last is accepted.
- Sits between producer blocks and a shared consumer (bus port or memory write channel), and owns the select of the mux feeding it.

Parameters:
- N, 4, number of requesters; legal range 2..64.
- WIDTH, 32, data bits per beat.
- SELW, $clog2(N), width of the encoded select; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- Req  input  N  Req[i] high: requester i has a beat to send.
- Last  input  N  Last[i] high: requester i's current beat ends its burst.
- DataIn  input  N*WIDTH  requester i's beat on DataIn[i*WIDTH +: WIDTH].
- OutReady  input  1  consumer accepts a beat this cycle.
- Gnt  output  N  one-hot registered grant; all-zero when idle.
- Sel  output  SELW  registered index of the granted requester.
- OutValid  output  1  beat presented to the consumer.
- OutData  output  WIDTH  DataIn word selected by Sel.
- OutLast  output  1  Last of the granted requester, gated by OutValid.
- Ack  output  N  per-requester beat accepted: Gnt[i] & OutValid & OutReady.
- Busy  output  1  high while a burst is locked.

Behaviour:
- Reset (asynchronous) values:
  - State=IDLE, Ptr=0.
  - Gnt=0, Sel=0, Busy=0.
  - OutValid=0, OutLast=0, Ack=0.
  - OutData=DataIn[0 +: WIDTH], since Sel=0.
- States: IDLE and BUSY.
- IDLE, with Req != 0:
  - Winner = first i with Req[i]=1, scanning Ptr, Ptr+1, ... N-1, 0, ... Ptr-1 (mod N).
  - Next edge: Gnt=onehot(winner), Sel=winner, State=BUSY.
- IDLE, with Req == 0: remain in IDLE; Gnt stays 0.
- Grant latency is exactly 1 cycle from Req seen in IDLE to Gnt high. No beat is transferred in IDLE.
- BUSY outputs (combinational from registered Sel):
  - OutValid = Req[Sel].
  - OutData = DataIn[Sel].
  - OutLast = Last[Sel] & OutValid.
- Beat transfer occurs on the cycle OutValid & OutReady are both high.
- Burst end: on a transfer with OutLast=1, at the next edge State=IDLE, Gnt=0, and Ptr=(Sel+1) mod N (wraps N-1 to 0).
- Non-final transfer: stay in BUSY; grant unchanged.
- Minimum one IDLE bubble cycle between bursts; no back-to-back re-grant.
- Requester drops Req mid-burst: OutValid=0, grant stays locked, no timeout. Requesters must not abandon a burst.
- Other requesters' Req/Last/DataIn are ignored while BUSY.
- OutReady high with OutValid low has no effect.
- Single-beat burst (Last=1 on first beat): BUSY lasts one cycle if OutReady=1.
- Ptr changes only at burst end; the last-served requester gets lowest priority.
- Reset asserted mid-burst: immediate return to the reset values above. The partial burst is discarded; the consumer sees OutValid drop asynchronously.
- Sel is never X. Gnt is always one-hot or zero (assertion in the bench).

Test Plan:
- Single requester, N=4: Req[2]=1 with a 3-beat burst (Last on beat 3), OutReady=1 -> Gnt=0100 one cycle after Req; Sel=2; OutData equals DataIn[2] on 3 consecutive Ack[2] cycles; returns to IDLE with Ptr=3.
- Contention: Req=1111, all single-beat, Ptr=0, OutReady=1 -> grant order 0,1,2,3,0; each burst takes 2 cycles (grant plus bubble).
- Pointer wrap: Ptr=3, Req=1001 -> requester 3 is granted first; after its burst Ptr=0 and requester 0 is granted next.
- Back-pressure: granted burst with OutReady toggling 0,1,0,0,1 -> transfers only on OutReady=1 cycles; OutData stable while OutValid=1 & OutReady=0; Gnt held throughout.
- Requester gap: Req[1] drops for 2 cycles mid-burst while Req[0]=1 -> OutValid=0 for those cycles, Gnt stays 0010, requester 0 not granted until requester 1's Last beat is accepted.
- Reset mid-burst: assert reset between clock edges during beat 2 of 4 -> Gnt=0, OutValid=0, Busy=0 immediately; after release with Req=0001, requester 0 is granted with Ptr=0 priority.
